// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues request-to-send,
// shifts out {stop, parity, byte} on device clock falls and samples the device ACK.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 100,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000,
  parameter int CNT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_command,
  input  logic [7:0] command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_sent,
  output logic       error
);
  typedef enum logic [3:0] {
    IDLE, INHIBIT, SETUP, WAIT_FIRST, SEND, WAIT_ACK, WAIT_IDLE, DONE, FAIL
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

  state_t           state;
  logic [1:0]       clk_sync, dat_sync;
  logic             clk_prev;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shift;
  logic [3:0]       bit_idx;
  logic             clk_s, dat_s, fall;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fall  = clk_prev & ~clk_s;

  // Idle bus is high, so synchronizers come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ps2_clk_oe   <= 1'b0;
      ps2_dat_oe   <= 1'b0;
      busy         <= 1'b0;
      command_sent <= 1'b0;
      error        <= 1'b0;
      cnt          <= '0;
      shift        <= '0;
      bit_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (send_command) begin
            shift      <= {1'b1, ~^command, command};
            cnt        <= '0;
            bit_idx    <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= SETUP;
          end else cnt <= cnt + 1'b1;
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= WAIT_FIRST;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_FIRST: begin
          if (fall) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= shift >> 1;
            bit_idx    <= 4'd1;
            cnt        <= '0;
            state      <= SEND;
          end else if (cnt == START_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            state      <= FAIL;
          end else cnt <= cnt + 1'b1;
        end
        // The transfer timeout spans SEND..WAIT_IDLE; the edge always takes priority.
        SEND: begin
          cnt <= cnt + 1'b1;
          if (fall) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= shift >> 1;
            bit_idx    <= bit_idx + 1'b1;
            if (bit_idx == 4'd9) state <= WAIT_ACK;
          end else if (cnt == XFER_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            state      <= FAIL;
          end
        end
        WAIT_ACK: begin
          cnt        <= cnt + 1'b1;
          ps2_dat_oe <= 1'b0;
          if (fall) begin
            if (!dat_s) state <= WAIT_IDLE;
            else begin
              ps2_clk_oe <= 1'b0;
              error      <= 1'b1;
              state      <= FAIL;
            end
          end else if (cnt == XFER_LAST) begin
            ps2_clk_oe <= 1'b0;
            error      <= 1'b1;
            state      <= FAIL;
          end
        end
        WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (clk_s && dat_s) begin
            command_sent <= 1'b1;
            state        <= DONE;
          end else if (cnt == XFER_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            error      <= 1'b1;
            state      <= FAIL;
          end
        end
        DONE: begin
          command_sent <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        FAIL: begin
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ps2_clk_oe   <= 1'b0;
          ps2_dat_oe   <= 1'b0;
          busy         <= 1'b0;
          command_sent <= 1'b0;
          error        <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule
